// File: rtl/jtpinpon_dwnld_pkg.sv
// Shared types and constants for the jtpinpon ROM download stage.
package jtpinpon_dwnld_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    PROM = 2'd2
  } state_t;

  // One buffered download byte: destination flag, remapped byte address, data.
  typedef struct packed {
    logic        is_prom;
    logic [22:0] addr;
    logic [7:0]  data;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  // Active-low SDRAM lane masks selected by the byte address LSB.
  localparam logic [1:0] MASK_EVEN = 2'b10;
  localparam logic [1:0] MASK_ODD  = 2'b01;

  // Region tests written as functions so a zero base does not fold into a constant compare.
  function automatic logic in_window(input logic [21:0] x, input logic [21:0] lo,
                                     input logic [21:0] hi);
    return (x >= lo) && (x < hi);
  endfunction

  function automatic logic at_or_above(input logic [24:0] x, input logic [24:0] base);
    return x >= base;
  endfunction

endpackage

// File: rtl/jtpinpon_dwnld_fifo.sv
// Synchronous show-ahead FIFO buffering download bytes against SDRAM back-pressure.
module jtpinpon_dwnld_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/jtpinpon_dwnld.sv
// ROM download stage: remaps char/obj bytes, buffers them and issues SDRAM or PROM writes.
// Define JTPINPON_DWNLD_CHKSUM_EN to add the chksum/chk_valid byte checksum ports.
module jtpinpon_dwnld
  import jtpinpon_dwnld_pkg::*;
#(
  parameter logic [21:0] SCR_START  = 22'h0,
  parameter logic [21:0] OBJ_START  = 22'h0,
  parameter logic [24:0] PROM_START = 25'h0,
  parameter int          DEPTH      = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        downloading,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        ioctl_wr,
  output logic [21:0] prog_addr,
  output logic [7:0]  prog_data,
  output logic [1:0]  prog_mask,
  output logic        prog_we,
  input  logic        prog_rdy,
  output logic        prom_we,
  output logic        dwn_done,
  output logic        overflow
`ifdef JTPINPON_DWNLD_CHKSUM_EN
  ,
  output logic [15:0] chksum,
  output logic        chk_valid
`endif
);

  state_t               state, state_nxt;
  entry_t               push_entry, pop_entry;
  logic [ENTRY_W-1:0]   rd_word;
  logic                 fifo_full, fifo_empty;
  logic                 push, pop;
  logic [21:0]          prom_idx;
  logic                 dl_q, dl_rise, dl_fall, armed, done_set;

  assign prom_idx = ioctl_addr[21:0] - PROM_START[21:0];

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    push_entry         = '0;
    push_entry.addr    = ioctl_addr[22:0];
    push_entry.data    = ioctl_dout;
    push_entry.is_prom = at_or_above(ioctl_addr, PROM_START);
    if (push_entry.is_prom) begin
      push_entry.addr = {prom_idx, 1'b0};
    end else if (in_window(ioctl_addr[21:0], SCR_START, OBJ_START)) begin
      push_entry.addr[0]   = ioctl_addr[3];
      push_entry.addr[3:1] = ioctl_addr[2:0] ^ 3'd1;
    end else if (in_window(ioctl_addr[21:0], OBJ_START, PROM_START[21:0])) begin
      push_entry.addr[0]   = ~ioctl_addr[3];
      push_entry.addr[1]   = ~ioctl_addr[4];
      push_entry.addr[5:2] = {ioctl_addr[5], ioctl_addr[2:0]};
    end
  end

  // A pop in the same cycle frees a slot, so a write at full is still taken then.
  assign push = ioctl_wr && (!fifo_full || pop);

  jtpinpon_dwnld_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push    (push),
    .pop     (pop),
    .wr_data (push_entry),
    .rd_data (rd_word),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign pop_entry = entry_t'(rd_word);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: if (!fifo_empty) begin
        pop       = 1'b1;
        state_nxt = pop_entry.is_prom ? PROM : WR;
      end
      WR:      if (prog_rdy) state_nxt = IDLE;
      PROM:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign prog_we = (state == WR);
  assign prom_we = (state == PROM);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prog_addr <= '0;
      prog_data <= '0;
      prog_mask <= '0;
    end else if (pop) begin
      prog_addr <= pop_entry.addr[22:1];
      prog_data <= pop_entry.data;
      prog_mask <= pop_entry.addr[0] ? MASK_ODD : MASK_EVEN;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                 overflow <= 1'b0;
    else if (ioctl_wr && fifo_full && !pop)    overflow <= 1'b1;
  end

  assign dl_rise  = downloading && !dl_q;
  assign dl_fall  = !downloading && dl_q;
  assign done_set = armed && !dl_rise && !dl_fall && fifo_empty && (state == IDLE);

  // End of download is reported only once the buffered bytes have all been written out.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dl_q     <= 1'b0;
      armed    <= 1'b0;
      dwn_done <= 1'b0;
    end else begin
      dl_q     <= downloading;
      dwn_done <= done_set;
      if (dl_rise)       armed <= 1'b0;
      else if (dl_fall)  armed <= 1'b1;
      else if (done_set) armed <= 1'b0;
    end
  end

`ifdef JTPINPON_DWNLD_CHKSUM_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      chksum    <= '0;
      chk_valid <= 1'b0;
    end else begin
      if (dl_rise)   chksum <= push ? {8'h00, ioctl_dout} : 16'h0000;
      else if (push) chksum <= chksum + {8'h00, ioctl_dout};
      if (dl_rise)       chk_valid <= 1'b0;
      else if (done_set) chk_valid <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_jtpinpon_dwnld.sv
// Directed self-checking bench for jtpinpon_dwnld: remap, PROM strobes, back-pressure, end, reset.
module tb_jtpinpon_dwnld;

  logic        clk = 1'b0;
  logic        rstn;
  logic        downloading;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wr;
  logic [21:0] prog_addr;
  logic [7:0]  prog_data;
  logic [1:0]  prog_mask;
  logic        prog_we;
  logic        prog_rdy;
  logic        prom_we;
  logic        dwn_done;
  logic        overflow;
`ifdef JTPINPON_DWNLD_CHKSUM_EN
  logic [15:0] chksum;
  logic        chk_valid;
  logic [15:0] exp_sum;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jtpinpon_dwnld #(
    .SCR_START  (22'h4000),
    .OBJ_START  (22'h8000),
    .PROM_START (25'h10000),
    .DEPTH      (4)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .downloading (downloading),
    .ioctl_addr  (ioctl_addr),
    .ioctl_dout  (ioctl_dout),
    .ioctl_wr    (ioctl_wr),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .prog_mask   (prog_mask),
    .prog_we     (prog_we),
    .prog_rdy    (prog_rdy),
    .prom_we     (prom_we),
    .dwn_done    (dwn_done),
    .overflow    (overflow)
`ifdef JTPINPON_DWNLD_CHKSUM_EN
    ,
    .chksum      (chksum),
    .chk_valid   (chk_valid)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [24:0] a, input logic [7:0] d, input bit taken);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
`ifdef JTPINPON_DWNLD_CHKSUM_EN
    if (taken) exp_sum = exp_sum + {8'h00, d};
`else
    if (taken) ;
`endif
  endtask

  task automatic wait_we(input string tag);
    for (int i = 0; i < 50; i++) begin
      if (prog_we) break;
      tick();
    end
    check(tag, prog_we, 1'b1);
  endtask

  task automatic accept();
    prog_rdy = 1'b1;
    tick();
    prog_rdy = 1'b0;
  endtask

  task automatic expect_write(input string tag, input logic [21:0] a, input logic [1:0] m,
                              input logic [7:0] d);
    wait_we({tag, "_we"});
    check({tag, "_addr"}, prog_addr, a);
    check({tag, "_mask"}, prog_mask, m);
    check({tag, "_data"}, prog_data, d);
  endtask

  int prom_cnt;
  int we_seen;
  logic [21:0] prom_addr;

  initial begin
    rstn        = 1'b0;
    downloading = 1'b0;
    ioctl_addr  = '0;
    ioctl_dout  = '0;
    ioctl_wr    = 1'b0;
    prog_rdy    = 1'b0;
`ifdef JTPINPON_DWNLD_CHKSUM_EN
    exp_sum     = '0;
`endif
    repeat (3) tick();
    check("rst_prog_we", prog_we, 1'b0);
    check("rst_prom_we", prom_we, 1'b0);
    check("rst_done", dwn_done, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_addr", prog_addr, 22'h0);
    rstn = 1'b1;
    tick();
    downloading = 1'b1;
    tick();

    // Char byte 0x4005: a[3]=0, a[2:0]=5^1=4 -> p=0x4008.
    push_byte(25'h4005, 8'h11, 1'b1);
    check("char_we_early", prog_we, 1'b0);
    expect_write("char", 22'h2004, 2'b10, 8'h11);
    repeat (3) tick();
    check("char_hold_we", prog_we, 1'b1);
    check("char_hold_addr", prog_addr, 22'h2004);
    accept();
    check("char_release", prog_we, 1'b0);

    // Char byte 0x400C: a[3]=1, a[2:0]=4^1=5 -> p=0x400B, odd lane.
    push_byte(25'h400C, 8'h33, 1'b1);
    expect_write("char_odd", 22'h2005, 2'b01, 8'h33);
    accept();

    // Obj byte 0x8018 -> p=0x8000.
    push_byte(25'h8018, 8'h22, 1'b1);
    expect_write("obj", 22'h4000, 2'b10, 8'h22);
    accept();

    // Below the char region: unchanged.
    push_byte(25'h1235, 8'h44, 1'b1);
    expect_write("pass", 22'h091A, 2'b01, 8'h44);
    accept();

    // PROM byte: one prom_we strobe, no SDRAM write.
    push_byte(25'h10123, 8'h5A, 1'b1);
    prom_cnt  = 0;
    we_seen   = 0;
    prom_addr = '0;
    for (int i = 0; i < 8; i++) begin
      if (prom_we) begin
        prom_cnt++;
        prom_addr = prog_addr;
        check("prom_data", prog_data, 8'h5A);
      end
      if (prog_we) we_seen++;
      tick();
    end
    check("prom_pulses", prom_cnt, 1);
    check("prom_index", prom_addr[10:0], 11'h123);
    check("prom_no_sdram", we_seen, 0);

    // Back-pressure: first byte sits in WR, four fill the FIFO, the sixth is dropped.
    for (int i = 0; i < 6; i++) begin
      push_byte(25'h0100 + 25'(2 * i), 8'hA0 + 8'(i), i < 5);
      tick();
    end
    check("bp_overflow", overflow, 1'b1);
    repeat (8) tick();
    for (int i = 0; i < 5; i++) begin
      expect_write($sformatf("bp%0d", i), 22'h80 + 22'(i), 2'b10, 8'hA0 + 8'(i));
      accept();
    end
    repeat (4) tick();
    check("bp_dropped", prog_we, 1'b0);
    check("bp_sticky", overflow, 1'b1);

    // End of download with two bytes still queued behind the one in WR.
    for (int i = 0; i < 3; i++) push_byte(25'h0200 + 25'(2 * i), 8'hB0 + 8'(i), 1'b1);
    downloading = 1'b0;
    repeat (3) tick();
    check("end_not_drained", dwn_done, 1'b0);
    for (int i = 0; i < 3; i++) begin
      expect_write($sformatf("end%0d", i), 22'h100 + 22'(i), 2'b10, 8'hB0 + 8'(i));
      check($sformatf("end%0d_nodone", i), dwn_done, 1'b0);
      accept();
    end
    check("end_after_rdy", dwn_done, 1'b0);
    tick();
    check("end_pulse", dwn_done, 1'b1);
`ifdef JTPINPON_DWNLD_CHKSUM_EN
    check("chk_valid", chk_valid, 1'b1);
    check("chksum", chksum, exp_sum);
`endif
    tick();
    check("end_pulse_once", dwn_done, 1'b0);

    // Reset in the middle of a held write, with the FIFO full and overflow set.
    downloading = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) push_byte(25'h0300 + 25'(2 * i), 8'hC0 + 8'(i), 1'b1);
    wait_we("rst_mid_we");
    check("rst_mid_ovf_pre", overflow, 1'b1);
    rstn = 1'b0;
    #1;
    check("rst_mid_we_low", prog_we, 1'b0);
    check("rst_mid_ovf", overflow, 1'b0);
    repeat (2) tick();
    rstn = 1'b1;
    repeat (6) tick();
    check("rst_mid_drained", prog_we, 1'b0);
    check("rst_mid_prom", prom_we, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
